// File: rtl/spike_window_gate.sv
// Trigger-opened time window that passes rising spike edges as one-cycle pulses.
// Optional build macro SPIKE_WINDOW_ONESHOT_EN limits each channel to one pulse per window.
module spike_window_gate #(
    parameter int unsigned P_CH   = 4,
    parameter int unsigned P_TRIG = 2,
    parameter int unsigned P_WIN  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [P_TRIG-1:0] i_trig,
    input  logic              i_retrig,
    input  logic [P_CH-1:0]   i_spike,
    output logic [P_CH-1:0]   o_spike,
    output logic              o_window,
    output logic              o_done
);

    localparam int unsigned     CntW   = $clog2(P_WIN + 1);
    localparam logic [CntW-1:0] WinMax = CntW'(P_WIN);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic {
        StIdle,
        StOpen
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              trig_prev_q, trig_prev_d;
    logic [P_CH-1:0]   spike_prev_q, spike_prev_d;
    logic [P_CH-1:0]   spike_q, spike_d;
    logic              done_q, done_d;

    logic              trig_edge;
    logic              restart;
    logic [P_CH-1:0]   spike_rise;
    logic [P_CH-1:0]   pulse;

    always_comb begin
        trig_prev_d  = |i_trig;
        spike_prev_d = i_spike;
        trig_edge    = (|i_trig) & ~trig_prev_q;
        spike_rise   = i_spike & ~spike_prev_q;

        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        restart = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (trig_edge) begin
                    state_d = StOpen;
                    count_d = CntOne;
                    restart = 1'b1;
                end else begin
                    count_d = '0;
                end
            end
            StOpen: begin
                // A retrigger wins over closing, so a restarted window never emits done.
                if (trig_edge && i_retrig) begin
                    count_d = CntOne;
                    restart = 1'b1;
                end else if (count_q == WinMax) begin
                    state_d = StIdle;
                    count_d = '0;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase

        // Gating uses the pre-edge state, so the closing edge still passes spikes.
        pulse = (state_q == StOpen) ? spike_rise : '0;
    end

`ifdef SPIKE_WINDOW_ONESHOT_EN
    logic [P_CH-1:0] fired_q, fired_d;

    always_comb begin
        spike_d = pulse & ~fired_q;
        fired_d = restart ? '0 : (fired_q | spike_d);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fired_q <= '0;
        end else begin
            fired_q <= fired_d;
        end
    end
`else
    always_comb begin
        spike_d = pulse;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            count_q      <= '0;
            trig_prev_q  <= 1'b0;
            spike_prev_q <= '0;
            spike_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            trig_prev_q  <= trig_prev_d;
            spike_prev_q <= spike_prev_d;
            spike_q      <= spike_d;
            done_q       <= done_d;
        end
    end

    assign o_spike  = spike_q;
    assign o_window = (state_q == StOpen);
    assign o_done   = done_q;

endmodule

// File: tb/tb_spike_window_gate.sv
// Directed bench for spike_window_gate: default instance plus a P_CH=8/P_TRIG=3/P_WIN=1 one.
module tb_spike_window_gate;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] trig;
    logic       retrig;
    logic [3:0] spike;
    logic [3:0] o_spike;
    logic       o_window;
    logic       o_done;

    logic [2:0] trig2;
    logic       retrig2;
    logic [7:0] spike2;
    logic [7:0] o_spike2;
    logic       o_window2;
    logic       o_done2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spike_window_gate u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_trig   (trig),
        .i_retrig (retrig),
        .i_spike  (spike),
        .o_spike  (o_spike),
        .o_window (o_window),
        .o_done   (o_done)
    );

    spike_window_gate #(
        .P_CH   (8),
        .P_TRIG (3),
        .P_WIN  (1)
    ) u_dut_w1 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_trig   (trig2),
        .i_retrig (retrig2),
        .i_spike  (spike2),
        .o_spike  (o_spike2),
        .o_window (o_window2),
        .o_done   (o_done2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; trig = '0; retrig = 1'b0; spike = '0;
        trig2 = '0; retrig2 = 1'b0; spike2 = '0;
        #3;
        check_eq("rst_window", 32'(o_window), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_spike", 32'(o_spike), 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        check_eq("idle_window", 32'(o_window), 32'd0);

        // Basic window: 4 cycles open, done on the 5th.
        trig = 2'b01;
        for (int k = 0; k < 6; k++) begin
            step();
            trig = '0;
            check_eq("basic_window", 32'(o_window), (k < 4) ? 32'd1 : 32'd0);
            check_eq("basic_done", 32'(o_done), (k == 4) ? 32'd1 : 32'd0);
        end

        // Rising spike inside the window pulses once; in idle it does not.
        trig = 2'b01;
        step(); trig = '0;
        step();
        spike = 4'b0100;
        step();
        check_eq("gate_pulse", 32'(o_spike), 32'h4);
        step();
        check_eq("gate_held", 32'(o_spike), 32'h0);
        spike = '0;
        step(); step(); step();
        check_eq("gate_closed", 32'(o_window), 32'd0);
        spike = 4'b0100;
        step();
        check_eq("idle_no_pulse", 32'(o_spike), 32'h0);
        spike = '0;
        step();

        // Level already high at window open never pulses.
        spike = 4'b0010;
        step();
        trig = 2'b10;
        step(); trig = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("prehigh_no_pulse", 32'(o_spike), 32'h0);
        end
        spike = '0;
        step(); step();

        // Retrigger on the edge where count is 2: 6 open cycles, single done.
        retrig = 1'b1;
        trig = 2'b01;
        for (int k = 0; k < 8; k++) begin
            step();
            trig = (k == 1) ? 2'b01 : 2'b00;
            check_eq("retrig_window", 32'(o_window), (k < 6) ? 32'd1 : 32'd0);
            check_eq("retrig_done", 32'(o_done), (k == 6) ? 32'd1 : 32'd0);
        end

        // Same trigger pattern without retrigger: plain 4-cycle window.
        retrig = 1'b0;
        trig = 2'b01;
        for (int k = 0; k < 6; k++) begin
            step();
            trig = (k == 1) ? 2'b01 : 2'b00;
            check_eq("noretrig_window", 32'(o_window), (k < 4) ? 32'd1 : 32'd0);
            check_eq("noretrig_done", 32'(o_done), (k == 4) ? 32'd1 : 32'd0);
        end
        step();

        // Toggling spike[0] through a window: rises sampled at open+1 and open+3.
        trig = 2'b01;
        spike = 4'b0000;
        step(); trig = '0;
        spike = 4'b0001; step();
        check_eq("toggle_p1", 32'(o_spike), 32'h1);
        spike = 4'b0000; step();
        check_eq("toggle_gap", 32'(o_spike), 32'h0);
        spike = 4'b0001; step();
`ifdef SPIKE_WINDOW_ONESHOT_EN
        check_eq("toggle_p2", 32'(o_spike), 32'h0);
`else
        check_eq("toggle_p2", 32'(o_spike), 32'h1);
`endif
        spike = 4'b0000; step();
        check_eq("toggle_done", 32'(o_done), 32'd1);
        step();

        // Reset mid-window aborts with no done.
        trig = 2'b01;
        step(); trig = '0;
        step();
        check_eq("pre_abort_window", 32'(o_window), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("abort_window", 32'(o_window), 32'd0);
        check_eq("abort_done", 32'(o_done), 32'd0);
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("abort_no_done", 32'(o_done) | 32'(o_window), 32'd0);
        end
        trig = 2'b10;
        for (int k = 0; k < 6; k++) begin
            step();
            trig = '0;
            check_eq("post_rst_window", 32'(o_window), (k < 4) ? 32'd1 : 32'd0);
            check_eq("post_rst_done", 32'(o_done), (k == 4) ? 32'd1 : 32'd0);
        end

        // Trigger held high through reset counts as an edge at the first clock.
        trig = 2'b01;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_eq("rel_edge_window", 32'(o_window), 32'd1);
        for (int k = 0; k < 5; k++) step();
        check_eq("held_no_reopen", 32'(o_window), 32'd0);
        trig = '0;
        step();

        // Narrow instance: one-cycle window, all 8 channels pulse on the closing edge.
        trig2 = 3'b100;
        step();
        check_eq("w1_window", 32'(o_window2), 32'd1);
        check_eq("w1_done_early", 32'(o_done2), 32'd0);
        trig2 = '0;
        spike2 = 8'hFF;
        step();
        check_eq("w1_closed", 32'(o_window2), 32'd0);
        check_eq("w1_done", 32'(o_done2), 32'd1);
        check_eq("w1_spikes", 32'(o_spike2), 32'hFF);
        step();
        check_eq("w1_done_clear", 32'(o_done2), 32'd0);
        check_eq("w1_spike_clear", 32'(o_spike2), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
